// File: rtl/mult_pkg.sv
// Shared state encoding and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

   // Callers extend operands into MaxW bits, so WIDTH must stay below MaxW.
   localparam int unsigned MaxW = 64;

   function automatic logic [MaxW-1:0] twos_mag(input logic [MaxW-1:0] v);
      return v[MaxW-1] ? (~v + MaxW'(1)) : v;
   endfunction

endpackage

// File: rtl/rca_adder.sv
// Parametrised ripple-carry adder with carry-in and carry-out.
module rca_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier, one partial product per clock,
// with unsigned/two's-complement modes and valid/ready handshakes.
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] y,
   output logic               busy
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned IdxW = $clog2(PW);
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [PW-1:0]     acc_q;
   logic [WIDTH-1:0]  mag_a_q;
   logic [WIDTH-1:0]  mag_b_q;
   logic              neg_q;

   logic [MaxW-1:0]   ext_a, ext_b;
   logic [WIDTH-1:0]  mag_a_in, mag_b_in;
   logic              neg_in;
   logic [IdxW-1:0]   idx;
   logic [WIDTH-1:0]  acc_win, add_sum;
   logic              add_cout;
   logic [PW-1:0]     acc_step;

   assign ext_a = signed_mode ? {{(MaxW - WIDTH){a[WIDTH-1]}}, a} : {{(MaxW - WIDTH){1'b0}}, a};
   assign ext_b = signed_mode ? {{(MaxW - WIDTH){b[WIDTH-1]}}, b} : {{(MaxW - WIDTH){1'b0}}, b};
   assign mag_a_in = WIDTH'(twos_mag(ext_a));
   assign mag_b_in = WIDTH'(twos_mag(ext_b));
   assign neg_in   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

   assign idx     = IdxW'(cnt_q);
   assign acc_win = acc_q[idx +: WIDTH];

   rca_adder #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (acc_win),
      .b    (mag_a_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // mag_b_q shifts right each cycle, so bit 0 is always the current multiplier bit.
   always_comb begin
      acc_step = acc_q;
      if (mag_b_q[0]) begin
         acc_step[idx +: WIDTH + 1] = {add_cout, add_sum};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         neg_q     <= 1'b0;
         y         <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  mag_a_q  <= mag_a_in;
                  mag_b_q  <= mag_b_in;
                  neg_q    <= neg_in;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= StBusy;
               end
            end
            StBusy: begin
               acc_q   <= acc_step;
               mag_b_q <= mag_b_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LastCnt) begin
                  y         <= neg_q ? (~acc_step + PW'(1)) : acc_step;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised, iterative radix-2 shift-and-add multiplier. Successor to the combinational 4x4 array multiplier.
- Trades area for latency: one partial product is added per clock, through a single WIDTH-bit adder.
- Adds a signed (two's-complement) mode and valid/ready handshakes on input and output.
- Sits between register-stage datapath blocks that need WIDTH x WIDTH products without a full array.

Parameters:
- WIDTH, 8: operand width in bits. Must be >= 2. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = a and b are two's complement; 0 = unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product.
- y  out  2*WIDTH  product. Two's complement when signed_mode was 1 at accept.
- busy  out  1  high while iterating (state BUSY).

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset (rst high at an edge): state=IDLE, counter=0, accumulator=0, y=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation (BUSY or DONE): aborts immediately. The pending product is discarded and never presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on an edge with in_valid & in_ready.
  - At accept, latch signed_mode.
  - Latch mag_a=|a| and mag_b=|b| (WIDTH-bit unsigned). In signed mode, the magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned.
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator, set counter=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: if mag_b[counter]==1, accumulator[counter+WIDTH : counter] += mag_a, with carry captured in bit counter+WIDTH.
  - Then counter increments.
  - On the edge where counter==WIDTH-1, the last bit is processed and the state goes to DONE.
  - On that same edge y is loaded with neg ? -(final accumulator) : final accumulator, where the negation is 2*WIDTH-bit two's complement. out_valid goes to 1.
- Latency: if accept happens on edge T, out_valid is first visible after edge T+WIDTH. This is fixed and independent of operand values; there is no early termination.
- DONE:
  - out_valid=1, in_ready=0.
  - y is held stable until an edge with out_ready=1. On that edge out_valid goes to 0 and the state goes to IDLE.
  - There is no accept on that same edge: a new accept is possible one cycle later, giving a throughput of 1 product per WIDTH+2 cycles.
- out_ready high outside DONE is ignored. in_valid outside IDLE is ignored, and the operands are not sampled.
- y keeps its last value after handoff and is only updated on entry to DONE. Consumers must qualify it with out_valid.
- Zero operand: iteration still runs the full WIDTH cycles, and y=0. Result is never -0: negation of 0 yields 0.
- Overflow: not possible. The 2*WIDTH-bit result holds every unsigned product and every signed product. The signed extreme, (-2^(W-1))^2 = 2^(2W-2), fits below 2^(2W-1).

Decomposition:
- Shared package mult_pkg:
  - State enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - A function returning the two's-complement magnitude of a WIDTH-bit value.
- One sub-module: rca_adder #(WIDTH), a parametrised ripple-carry adder with a carry-out. It is instantiated once for the per-cycle partial-product add.
- The two's-complement negations use plain arithmetic, not rca_adder.

Test Plan:
1. Reset, then WIDTH=8, unsigned, a=12, b=15 accepted at edge T -> busy high for 8 cycles; out_valid rises after T+8 with y=180. With out_ready=1, out_valid falls on the next edge.
2. Signed, a=-128 (8'h80), b=-128 -> y=16384 (16'h4000). Signed, a=-5, b=7 -> y=-35 (16'hFFDD). Signed, a=0, b=-1 -> y=0.
3. Back-pressure: product a=8, b=13 unsigned (y=104) with out_ready held low 5 cycles -> y=104 and out_valid stay stable. in_ready stays 0, and an in_valid pulse with a=3, b=3 during this time is ignored. After out_ready=1, the next accepted op yields 9.
4. rst asserted mid-BUSY (counter=3) -> next cycle out_valid=0, y=0, busy=0, in_ready=1. The aborted product never appears.
5. WIDTH=4 instance: exhaustive 256 unsigned and 256 signed operand pairs, each result checked against the reference product. Each result must have latency of exactly 4 edges from accept.
6. Streaming with in_valid and out_ready tied high -> a new product completes every WIDTH+2 cycles, and no operand is lost or duplicated.
